// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared parameters, slice helpers and stage record for the pipelined adder
package adder_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CHUNK = 8;

    // Number of pipeline stages: one per CHUNK-bit slice.
    function automatic int stages_of(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Bit offset of slice k within the full-width word.
    function automatic int chunk_lo(input int k, input int chunk);
        return k * chunk;
    endfunction

    // Per-stage record handed from one slice to the next.
    typedef struct packed {
        logic valid;
        logic carry;
        logic zero;
    } stage_rec_t;

endpackage

// File: rtl/pipelined_carry_adder_if.sv
// rtl/pipelined_carry_adder_if.sv - operand/result handshake bundle for the pipelined adder
interface pipelined_carry_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow, zero
    );
endinterface

// File: rtl/adder_slice.sv
// rtl/adder_slice.sv - one registered CHUNK-bit add stage with carry-in and advance enable
module adder_slice
    import adder_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             adv,
    input  logic             vin,
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    input  logic             zin,
    output stage_rec_t       rec,
    output logic             carry_msb,
    output logic [CHUNK-1:0] sum
);

    logic [CHUNK:0] raw;

    assign raw = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

    // Valid follows the pipeline on every advance; data only loads for a real beat.
    // Zero accumulates across slices so the last stage holds the full-word flag.
    // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            rec       <= '0;
            carry_msb <= 1'b0;
            sum       <= '0;
        end else if (adv) begin
            rec.valid <= vin;
            if (vin) begin
                sum       <= raw[CHUNK-1:0];
                rec.carry <= raw[CHUNK];
                rec.zero  <= zin & ~|raw[CHUNK-1:0];
                carry_msb <= raw[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
            end
        end
    end

endmodule

// File: rtl/pipelined_carry_adder.sv
// rtl/pipelined_carry_adder.sv - carry-rippled add/subtract pipeline, one register stage per slice
module pipelined_carry_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic                    clk,
    input  logic                    reset,
    pipelined_carry_adder_if.slave  io
);

    localparam int STAGES = stages_of(WIDTH, CHUNK);

    if (((WIDTH % CHUNK) != 0) || (STAGES < 1)) begin : g_bad_cfg
        $fatal(1, "pipelined_carry_adder: WIDTH must be a non-zero multiple of CHUNK");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic [WIDTH-1:0] sum_w;

    stage_rec_t       stage      [STAGES];
    logic [CHUNK-1:0] op_a       [STAGES];
    logic [CHUNK-1:0] op_b       [STAGES];
    logic [CHUNK-1:0] slice_sum  [STAGES];
    logic [CHUNK-1:0] out_chunk  [STAGES];
    logic             slice_cmsb [STAGES];
    logic             slice_vin  [STAGES];
    logic             slice_cin  [STAGES];
    logic             slice_zin  [STAGES];

    // The whole pipeline moves as one; a held result freezes every register.
    assign adv         = !io.out_valid || io.out_ready;
    assign io.in_ready = adv;

    // Subtraction as a + ~b + ~borrow.
    assign b_eff = io.b ^ {WIDTH{io.sub}};
    assign c0    = io.sub ^ io.cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = chunk_lo(k, CHUNK);

        if (k == 0) begin : g_head
            assign op_a[k]      = io.a[LO +: CHUNK];
            assign op_b[k]      = b_eff[LO +: CHUNK];
            assign slice_vin[k] = io.in_valid;
            assign slice_cin[k] = c0;
            assign slice_zin[k] = 1'b1;
        end else begin : g_skew
            logic [CHUNK-1:0] ska [k];
            logic [CHUNK-1:0] skb [k];

            // Operand skew: entry j travels alongside the beat sitting in stage j.
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int j = 0; j < k; j++) begin
                        ska[j] <= '0;
                        skb[j] <= '0;
                    end
                end else if (adv) begin
                    if (io.in_valid) begin
                        ska[0] <= io.a[LO +: CHUNK];
                        skb[0] <= b_eff[LO +: CHUNK];
                    end
                    for (int j = 1; j < k; j++) begin
                        if (stage[j-1].valid) begin
                            ska[j] <= ska[j-1];
                            skb[j] <= skb[j-1];
                        end
                    end
                end
            end

            assign op_a[k]      = ska[k-1];
            assign op_b[k]      = skb[k-1];
            assign slice_vin[k] = stage[k-1].valid;
            assign slice_cin[k] = stage[k-1].carry;
            assign slice_zin[k] = stage[k-1].zero;
        end

        adder_slice #(
            .CHUNK(CHUNK)
        ) u_slice (
            .clk      (clk),
            .reset    (reset),
            .adv      (adv),
            .vin      (slice_vin[k]),
            .a        (op_a[k]),
            .b        (op_b[k]),
            .cin      (slice_cin[k]),
            .zin      (slice_zin[k]),
            .rec      (stage[k]),
            .carry_msb(slice_cmsb[k]),
            .sum      (slice_sum[k])
        );

        if (k < STAGES - 1) begin : g_deskew
            localparam int D = STAGES - 1 - k;
            logic [CHUNK-1:0] dsk [D];

            // Result deskew: entry j holds this slice's bits for the beat in stage k+1+j.
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int j = 0; j < D; j++) begin
                        dsk[j] <= '0;
                    end
                end else if (adv) begin
                    if (stage[k].valid) begin
                        dsk[0] <= slice_sum[k];
                    end
                    for (int j = 1; j < D; j++) begin
                        if (stage[k+j].valid) begin
                            dsk[j] <= dsk[j-1];
                        end
                    end
                end
            end

            assign out_chunk[k] = dsk[D-1];
        end else begin : g_tail
            assign out_chunk[k] = slice_sum[k];
        end

        assign sum_w[LO +: CHUNK] = out_chunk[k];
    end

    assign io.sum       = sum_w;
    assign io.out_valid = stage[STAGES-1].valid;
    assign io.cout      = stage[STAGES-1].carry;
    assign io.zero      = stage[STAGES-1].zero;
    assign io.overflow  = slice_cmsb[STAGES-1] ^ stage[STAGES-1].carry;

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// tb/tb_pipelined_carry_adder.sv - directed and streaming checks for the pipelined adder
module tb_pipelined_carry_adder;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pipelined_carry_adder_if #(.WIDTH(8))  if8  ();
    pipelined_carry_adder_if #(.WIDTH(32)) if32 ();
    pipelined_carry_adder_if #(.WIDTH(16)) if16 ();

    pipelined_carry_adder #(.WIDTH(8),  .CHUNK(4))  dut8  (.clk(clk), .reset(reset), .io(if8));
    pipelined_carry_adder #(.WIDTH(32), .CHUNK(8))  dut32 (.clk(clk), .reset(reset), .io(if32));
    pipelined_carry_adder #(.WIDTH(16), .CHUNK(16)) dut16 (.clk(clk), .reset(reset), .io(if16));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [34:0] got, input logic [34:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input int sel, input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub);
        case (sel)
            0: begin if8.in_valid = v;  if8.a = a[7:0];   if8.b = b[7:0];   if8.cin = cin;  if8.sub = sub;  end
            1: begin if32.in_valid = v; if32.a = a;       if32.b = b;       if32.cin = cin; if32.sub = sub; end
            default: begin if16.in_valid = v; if16.a = a[15:0]; if16.b = b[15:0]; if16.cin = cin; if16.sub = sub; end
        endcase
    endtask

    function automatic logic [31:0] rd_sum(input int sel);
        case (sel)
            0:       return {24'd0, if8.sum};
            1:       return if32.sum;
            default: return {16'd0, if16.sum};
        endcase
    endfunction

    // {out_valid, in_ready, cout, overflow, zero}
    function automatic logic [4:0] rd_st(input int sel);
        case (sel)
            0:       return {if8.out_valid,  if8.in_ready,  if8.cout,  if8.overflow,  if8.zero};
            1:       return {if32.out_valid, if32.in_ready, if32.cout, if32.overflow, if32.zero};
            default: return {if16.out_valid, if16.in_ready, if16.cout, if16.overflow, if16.zero};
        endcase
    endfunction

    // 32-bit reference: {cout, overflow, zero, sum}
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
        logic [31:0] be;
        logic        ci;
        logic [32:0] r;
        logic        ovf;
        be  = sub ? ~b : b;
        ci  = sub ? ~cin : cin;
        r   = {1'b0, a} + {1'b0, be} + {32'd0, ci};
        ovf = (a[31] == be[31]) && (r[31] != a[31]);
        return {r[32], ovf, (r[31:0] == 32'd0), r[31:0]};
    endfunction

    // One isolated beat with out_ready held high; checks latency, sum and flags.
    task automatic beat(input string tag, input int sel, input int lat,
                        input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub,
                        input logic [31:0] esum, input logic [2:0] eflags);
        int         cyc;
        logic [4:0] st;
        @(negedge clk);
        set_in(sel, 1'b1, a, b, cin, sub);
        #1;
        st = rd_st(sel);
        check({tag, ".in_ready"}, 35'(st[3]), 35'd1);
        @(negedge clk);
        set_in(sel, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        cyc = 1;
        st  = rd_st(sel);
        while (!st[4] && cyc < 20) begin
            @(negedge clk);
            cyc++;
            st = rd_st(sel);
        end
        check({tag, ".latency"}, 35'(cyc), 35'(lat));
        check({tag, ".sum"}, 35'(rd_sum(sel)), 35'(esum));
        check({tag, ".flags"}, 35'(st[2:0]), 35'(eflags));
        @(negedge clk);
        st = rd_st(sel);
        check({tag, ".drained"}, 35'(st[4]), 35'd0);
    endtask

    logic [31:0] ba [16];
    logic [31:0] bb [16];
    logic        bc [16];
    logic        bs [16];
    logic [34:0] expq [$];

    initial begin
        int          sent;
        int          got;
        int          cyc;
        int          stale;
        logic        hold;
        logic [31:0] hsum;
        logic [2:0]  hflags;
        logic [4:0]  st;
        logic [34:0] e;

        reset = 1'b1;
        if8.out_ready = 1'b1;
        if32.out_ready = 1'b1;
        if16.out_ready = 1'b1;
        for (int s = 0; s < 3; s++) set_in(s, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state on every configuration
        for (int s = 0; s < 3; s++) begin
            check($sformatf("reset.status%0d", s), 35'(rd_st(s)), 35'(5'b01000));
            check($sformatf("reset.sum%0d", s), 35'(rd_sum(s)), 35'd0);
        end

        // 8-bit, two 4-bit stages
        beat("w8.add14p8",  0, 2, 32'd14,   32'd8,    1'b0, 1'b0, 32'h16, 3'b000);
        beat("w8.ffp01",    0, 2, 32'hFF,   32'h01,   1'b0, 1'b0, 32'h00, 3'b101);
        beat("w8.7fp01",    0, 2, 32'h7F,   32'h01,   1'b0, 1'b0, 32'h80, 3'b010);
        beat("w8.80m01",    0, 2, 32'h80,   32'h01,   1'b0, 1'b1, 32'h7F, 3'b110);
        // 32-bit, four 8-bit stages, subtract
        beat("w32.5m7",     1, 4, 32'd5,    32'd7,    1'b0, 1'b1, 32'hFFFFFFFE, 3'b000);
        beat("w32.7m5b",    1, 4, 32'd7,    32'd5,    1'b1, 1'b1, 32'd1,        3'b100);
        // 16-bit single stage
        beat("w16.8000x2",  2, 1, 32'h8000, 32'h8000, 1'b0, 1'b0, 32'h0,  3'b111);

        // Streaming with random gaps and random backpressure
        for (int i = 0; i < 16; i++) begin
            ba[i] = $urandom;
            bb[i] = $urandom;
            bc[i] = 1'($urandom_range(0, 1));
            bs[i] = 1'($urandom_range(0, 1));
        end
        ba[3] = 32'h7FFFFFFF; bb[3] = 32'h00000001; bc[3] = 1'b0; bs[3] = 1'b0;
        ba[7] = 32'h12345678; bb[7] = 32'h12345678; bc[7] = 1'b0; bs[7] = 1'b1;
        sent = 0;
        got  = 0;
        cyc  = 0;
        hold = 1'b0;
        hsum = '0;
        hflags = '0;
        while (got < 16 && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (hold) begin
                st = rd_st(1);
                check("stall.valid",    35'(st[4]), 35'd1);
                check("stall.in_ready", 35'(st[3]), 35'd0);
                check("stall.sum",      35'(rd_sum(1)), 35'(hsum));
                check("stall.flags",    35'(st[2:0]), 35'(hflags));
            end
            if32.out_ready = 1'($urandom_range(0, 1));
            if (sent < 16 && $urandom_range(0, 3) != 0)
                set_in(1, 1'b1, ba[sent], bb[sent], bc[sent], bs[sent]);
            else
                set_in(1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
            #1;
            st = rd_st(1);
            if (st[4] && if32.out_ready) begin
                if (expq.size() == 0) begin
                    check("stream.extra_beat", 35'd1, 35'd0);
                end else begin
                    e = expq.pop_front();
                    check($sformatf("stream.beat%0d", got), {st[2:0], rd_sum(1)}, e);
                end
                got++;
            end
            if (if32.in_valid && st[3]) begin
                expq.push_back(model(ba[sent], bb[sent], bc[sent], bs[sent]));
                sent++;
            end
            hold   = st[4] && !if32.out_ready;
            hsum   = rd_sum(1);
            hflags = st[2:0];
        end
        check("stream.count", 35'(got), 35'd16);
        check("stream.queue_empty", 35'(expq.size()), 35'd0);
        @(negedge clk);
        set_in(1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        if32.out_ready = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            st = rd_st(1);
            if (st[4]) stale++;
        end
        check("stream.no_duplicate", 35'(stale), 35'd0);

        // Reset with three beats in flight
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_in(1, 1'b1, 32'(i + 1), 32'(10 * i), 1'b0, 1'b0);
        end
        @(negedge clk);
        reset = 1'b1;
        set_in(1, 1'b1, 32'h55, 32'h55, 1'b0, 1'b0);
        @(negedge clk);
        st = rd_st(1);
        check("rst.out_valid", 35'(st[4]), 35'd0);
        check("rst.sum", 35'(rd_sum(1)), 35'd0);
        reset = 1'b0;
        set_in(1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            st = rd_st(1);
            if (st[4]) stale++;
        end
        check("rst.no_stale", 35'(stale), 35'd0);
        beat("rst.next", 1, 4, 32'd100, 32'd23, 1'b0, 1'b0, 32'd123, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipelined_carry_adder.md
# pipelined_carry_adder

Parametrised, pipelined add/subtract unit that splits a WIDTH-bit operation into CHUNK-bit slices and ripples the carry through one register stage per slice. It returns a full-width sum, carry-out, signed overflow and zero flags, and uses a valid/ready handshake with backpressure. It is the general successor to the fixed 4-bit add-with-carry datapath and serves as the ALU adder candidate for the RISC-V core, where a long carry chain limits timing.

## Interface
- WIDTH, 32, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, slice width per pipeline stage; STAGES = WIDTH/CHUNK (≥1).
- clk  input  1  sole clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  unit accepts a beat this cycle.
- a, b  input  WIDTH  operands.
- cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0: a+b+cin; 1: a−b−cin.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry-out of MSB (for sub: 1 = no borrow).
- overflow  output  1  signed two's-complement overflow.
- zero  output  1  sum == 0.

## Operation
- Slice k (0 = LSB) computes bits [k*CHUNK +: CHUNK] in stage k, using the carry registered out of stage k−1.
- Stage 0 carry-in c0 = sub ? ~cin : cin; the b operand is b ^ {WIDTH{sub}}.
- Operand skew: slice k operands are delayed k cycles before stage k. Result deskew: slice k result is delayed STAGES−1−k cycles, so all slices of one beat emerge together.
- Each stage holds a valid bit; data regs load only when valid is accepted (no X propagation into flags).
- Global advance enable adv = !out_valid || out_ready; all pipeline registers, including skew/deskew, move only when adv = 1. in_ready = adv.
- Flags at final stage: cout = carry out of slice STAGES−1. overflow = carry into MSB XOR carry out of MSB (the carry into MSB is taken inside the last slice). zero = ~|sum.
- Width rule: the 5-bit-style widening is replaced by sum[WIDTH−1:0] plus cout; concatenation {cout,sum} equals the unsigned WIDTH+1-bit result for add.
- STAGES = 1 degenerates to a single registered adder, latency 1.

## Timing
- Latency: STAGES cycles from accepted input (in_valid && in_ready) to out_valid, with no stalls.
- Throughput: one beat per cycle while out_ready = 1.
- Stall: out_valid && !out_ready holds the entire pipeline; sum/flags stay stable and in_ready = 0. Bubbles are not squeezed out.
- Simultaneous accept and drain in the same cycle is legal and lossless.
- Reset: all valid bits go to 0. out_valid = 0, in_ready = 1 the cycle after reset; sum = 0, cout = 0, overflow = 0, zero = 0 (registered flag cleared). Reset mid-operation discards all in-flight beats. Reset dominates out_ready and in_valid.
- Inputs are sampled only on accept; a, b, cin and sub may change freely otherwise.

## Structure
- Shared package adder_pkg: the localparam formula for STAGES, a function computing chunk slice offsets, and a typedef for the per-stage carry/valid record.
- One sub-module, adder_slice: a registered CHUNK-bit add with carry-in/enable, producing sum, carry-out and carry-into-MSB. It is instantiated STAGES times by a generate loop.
- Skew/deskew delay lines are inline generate shift registers, not a separate module.
- Elaboration check: WIDTH % CHUNK != 0 triggers $fatal.

## Test plan
- WIDTH=8, CHUNK=4: a=14, b=8, cin=0, sub=0 -> after 2 cycles sum=22, cout=0, overflow=0, zero=0.
- WIDTH=8, CHUNK=4: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, zero=1, overflow=0; a=0x7F, b=0x01 -> sum=0x80, overflow=1.
- WIDTH=32, CHUNK=8, sub=1: a=5, b=7, cin=0 -> sum=0xFFFFFFFE, cout=0; a=7, b=5, cin=1 -> sum=1, cout=1.
- Back-to-back stream of 16 random beats with out_ready toggling pseudo-randomly -> results in order, none lost or duplicated, sum/flags stable throughout every stall. Compare against a reference model.
- Reset asserted with 3 beats in flight (WIDTH=32, CHUNK=8) -> out_valid=0 the next cycle, no stale beat appears afterwards, and the next accepted beat has latency 4.
- WIDTH=16, CHUNK=16 (STAGES=1): a=0x8000, b=0x8000 -> one cycle later sum=0, cout=1, overflow=1, zero=1.
